// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared types, constants and small helpers for the iterative
//                multiply/divide unit (op and state encodings, word types).
//  Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    typedef logic        bit_t;
    typedef logic [31:0] word_t;
    typedef logic [63:0] doubleword_t;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } muldiv_state_t;

    localparam int unsigned MULDIV_ITERS = 32;
    localparam doubleword_t ZERO_DWORD   = 64'h0;

    // Two's-complement magnitude; 0x80000000 maps to itself, which is the
    // correct magnitude once read as unsigned.
    function automatic word_t abs_word(input word_t v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    function automatic bit_t op_is_signed(input muldiv_op_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic bit_t op_is_div(input muldiv_op_t op);
        return op[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_if
//  Description : Request/result bundle between the issuing pipeline stage
//                (master) and the multiply/divide unit (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_if;
    import muldiv_pkg::*;

    bit_t        start;
    muldiv_op_t  op;
    word_t       opa;
    word_t       opb;
    bit_t        cancel;
    bit_t        busy;
    bit_t        result_valid;
    doubleword_t result;

    modport master (
        output start, op, opa, opb, cancel,
        input  busy, result_valid, result
    );

    modport slave (
        input  start, op, opa, opb, cancel,
        output busy, result_valid, result
    );

endinterface
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_step
//  Description : One combinational iteration of the shared datapath.
//                Multiply: shift-add, consumes multiplier LSB held in acc_lo.
//                Divide  : restoring step, shifts dividend MSB out of acc_lo
//                          into the partial remainder, quotient bit into LSB.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step
    import muldiv_pkg::*;
(
    input  wire bit_t  i_is_div,
    input  wire word_t i_acc_hi,   // mul: product high half / div: remainder
    input  wire word_t i_acc_lo,   // mul: multiplier bits   / div: dividend->quotient
    input  wire word_t i_oper,     // mul: multiplicand      / div: divisor
    output word_t      o_acc_hi,
    output word_t      o_acc_lo
);

    logic [32:0] w_sum;
    logic [32:0] w_prem;
    word_t       w_diff;
    bit_t        w_ge;

    // Single-iteration arithmetic for both op classes, selected by i_is_div
    always_comb begin
        w_sum  = {1'b0, i_acc_hi} + (i_acc_lo[0] ? {1'b0, i_oper} : 33'd0);
        w_prem = {i_acc_hi, i_acc_lo[31]};
        w_ge   = (w_prem >= {1'b0, i_oper});
        // When w_ge holds the true difference is below 2^32, so the low word suffices
        w_diff = w_prem[31:0] - i_oper;

        if (i_is_div) begin
            o_acc_hi = w_ge ? w_diff : w_prem[31:0];
            o_acc_lo = {i_acc_lo[30:0], w_ge};
        end else begin
            o_acc_hi = w_sum[32:1];
            o_acc_lo = {w_sum[0], i_acc_lo[31:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative 32x32 MULT/MULTU/DIV/DIVU unit feeding HI/LO.
//                Fixed 34-edge latency from acceptance to the cycle in which
//                result_valid pulses; cancel aborts any operation in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned ITERS = MULDIV_ITERS
)(
    input  wire logic clk,
    input  wire logic rst_n,
    muldiv_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(ITERS);

    muldiv_state_t     state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    muldiv_op_t        op_q,     op_d;
    word_t             opa_q,    opa_d;
    word_t             opb_q,    opb_d;
    word_t             oper_q,   oper_d;
    word_t             acc_hi_q, acc_hi_d;
    word_t             acc_lo_q, acc_lo_d;
    bit_t              neg_quot_q, neg_quot_d;
    bit_t              neg_rem_q,  neg_rem_d;
    bit_t              divz_q,     divz_d;
    doubleword_t       result_q,   result_d;

    word_t             w_step_hi;
    word_t             w_step_lo;
    bit_t              w_sa;
    bit_t              w_sb;
    word_t             w_mag_a;
    word_t             w_mag_b;
    doubleword_t       w_prod;

    muldiv_step u_step (
        .i_is_div (op_is_div(op_q)),
        .i_acc_hi (acc_hi_q),
        .i_acc_lo (acc_lo_q),
        .i_oper   (oper_q),
        .o_acc_hi (w_step_hi),
        .o_acc_lo (w_step_lo)
    );

    // Next-state, operand latch, iteration and sign-fix logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        oper_d     = oper_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        divz_d     = divz_q;
        result_d   = result_q;

        w_sa    = op_is_signed(op_q) & opa_q[31];
        w_sb    = op_is_signed(op_q) & opb_q[31];
        w_mag_a = w_sa ? abs_word(opa_q) : opa_q;
        w_mag_b = w_sb ? abs_word(opb_q) : opb_q;
        w_prod  = {acc_hi_q, acc_lo_q};

        if (bus.cancel) begin
            // Flush wins over everything, including a simultaneous start
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state_d = ST_PREP;
                        op_d    = bus.op;
                        opa_d   = bus.opa;
                        opb_d   = bus.opb;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PREP: begin
                    state_d    = ST_ITER;
                    cnt_d      = '0;
                    acc_hi_d   = '0;
                    neg_quot_d = w_sa ^ w_sb;
                    neg_rem_d  = w_sa;
                    divz_d     = op_is_div(op_q) && (opb_q == 32'd0);
                    if (op_is_div(op_q)) begin
                        acc_lo_d = w_mag_a;
                        oper_d   = w_mag_b;
                    end else begin
                        acc_lo_d = w_mag_b;
                        oper_d   = w_mag_a;
                    end
                end
                ST_ITER: begin
                    acc_hi_d = w_step_hi;
                    acc_lo_d = w_step_lo;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITERS - 1)) begin
                        state_d = ST_FIX;
                    end
                end
                ST_FIX: begin
                    state_d = ST_DONE;
                    if (!op_is_div(op_q)) begin
                        result_d = neg_quot_q ? (ZERO_DWORD - w_prod) : w_prod;
                    end else if (divz_q) begin
                        // Divide by zero returns the raw dividend, not its magnitude
                        result_d = {opa_q, 32'hFFFF_FFFF};
                    end else begin
                        result_d = {neg_rem_q  ? (32'd0 - acc_hi_q) : acc_hi_q,
                                    neg_quot_q ? (32'd0 - acc_lo_q) : acc_lo_q};
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers; reset discards any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_q       <= OP_MULT;
            opa_q      <= '0;
            opb_q      <= '0;
            oper_q     <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            divz_q     <= 1'b0;
            result_q   <= ZERO_DWORD;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            oper_q     <= oper_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            divz_q     <= divz_d;
            result_q   <= result_d;
        end
    end

    // Status decoded straight from the state register, so no input reaches it combinationally
    assign bus.busy         = (state_q == ST_PREP) || (state_q == ST_ITER) || (state_q == ST_FIX);
    assign bus.result_valid = (state_q == ST_DONE);
    assign bus.result       = result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Self-checking bench for muldiv_unit with an edge-counting
//                behavioural model and arithmetic reference results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    bit   chk_en;

    muldiv_if bus();

    muldiv_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference: what {hi,lo} must be for one operation
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] pa, pb, pp;
        logic signed [31:0] sa, sb;
        logic [31:0] q, r;
        case (op)
            2'd0: begin
                pa = {{32{a[31]}}, a};
                pb = {{32{b[31]}}, b};
                pp = pa * pb;
                return pp;
            end
            2'd1: return {32'h0, a} * {32'h0, b};
            2'd2: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                sa = a; sb = b;
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Model: k = edges since acceptance (0 = nothing in flight)
    int          k;
    logic [63:0] m_pend;
    logic [63:0] m_result;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k = 0;
            m_result = 64'h0;
        end else if (bus.cancel) begin
            k = 0;
        end else if ((k == 0 || k == 35) && bus.start) begin
            k = 1;
            m_pend = ref_result(bus.op, bus.opa, bus.opb);
        end else if (k == 35) begin
            k = 0;
        end else if (k != 0) begin
            k = k + 1;
            if (k == 35) m_result = m_pend;
        end
    end

    // Cycle-by-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("busy", {63'h0, bus.busy}, {63'h0, (k >= 1 && k <= 34)});
            check("result_valid", {63'h0, bus.result_valid}, {63'h0, (k == 35)});
            check("result", bus.result, m_result);
        end
    end

    // Issue one op at the current negedge; return at the negedge where result_valid is seen
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input bit poke);
        int n;
        bus.start = 1'b1;
        bus.op    = muldiv_op_t'(op);
        bus.opa   = a;
        bus.opb   = b;
        @(negedge clk);
        n = 1;
        bus.start = 1'b0;
        bus.op    = muldiv_op_t'(2'($urandom_range(0, 3)));
        bus.opa   = $urandom;
        bus.opb   = $urandom;
        while (!bus.result_valid && n < 40) begin
            bus.start = (poke && n == 5);
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        check("latency", 64'(n), 64'd35);
        check("op_result", bus.result, exp);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        bit          no_valid;
        n_tests = 0;
        n_fail  = 0;
        chk_en  = 1'b0;
        rst_n   = 1'b0;
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        bus.op     = OP_MULT;
        bus.opa    = '0;
        bus.opb    = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", {63'h0, bus.busy}, 64'h0);
        check("reset_valid", {63'h0, bus.result_valid}, 64'h0);
        check("reset_result", bus.result, 64'h0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // Directed values with hand-computed results
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
        @(negedge clk);
        check("valid_one_cycle", {63'h0, bus.result_valid}, 64'h0);
        run_op(2'd0, 32'hFFFF_FFFF, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
        run_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        run_op(2'd3, 32'h0000_0007, 32'h0000_0002, 64'h0000_0001_0000_0003, 1'b0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b1);
        run_op(2'd3, 32'h0000_1234, 32'h0000_0000, 64'h0000_1234_FFFF_FFFF, 1'b0);
        run_op(2'd2, 32'hFFFF_FFF0, 32'h0000_0000, 64'hFFFF_FFF0_FFFF_FFFF, 1'b0);
        @(negedge clk);

        // Cancel during the 10th ITER cycle
        bus.start = 1'b1; bus.op = OP_DIVU; bus.opa = 32'd1000; bus.opb = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        check("cancel_busy", {63'h0, bus.busy}, 64'h0);
        no_valid = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (bus.result_valid) no_valid = 1'b0;
        end
        check("cancel_no_valid", {63'h0, no_valid}, 64'h1);
        run_op(2'd3, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b0);
        @(negedge clk);

        // start and cancel together from IDLE
        bus.start = 1'b1; bus.cancel = 1'b1; bus.op = OP_MULTU;
        @(negedge clk);
        bus.start = 1'b0; bus.cancel = 1'b0;
        check("start_cancel_busy", {63'h0, bus.busy}, 64'h0);
        @(negedge clk);

        // cancel in DONE blocks a simultaneous start
        run_op(2'd1, 32'd3, 32'd5, 64'd15, 1'b0);
        bus.start = 1'b1; bus.cancel = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.cancel = 1'b0;
        check("done_cancel_busy", {63'h0, bus.busy}, 64'h0);
        @(negedge clk);

        // Randomized operations, mostly back-to-back from the DONE cycle
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: begin ra = $urandom_range(0, 300); rb = $urandom_range(1, 20); end
                default: ;
            endcase
            run_op(rop, ra, rb, ref_result(rop, ra, rb), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        @(negedge clk);

        // Asynchronous reset mid-ITER
        bus.start = 1'b1; bus.op = OP_MULTU; bus.opa = 32'h1234_5678; bus.opb = 32'h9ABC_DEF0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {63'h0, bus.busy}, 64'h0);
        check("arst_valid", {63'h0, bus.result_valid}, 64'h0);
        check("arst_result", bus.result, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run_op(2'd3, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b0);
        repeat (2) @(negedge clk);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
